// File: rtl/pdc_wr_sched.sv
// ---------------------------------------------------------------------------
// pdc_wr_sched
//   Write-port controller for the pdc RAM. It is the only source of the RAM's
//   write_addr/write_data/write_wen. After reset, and whenever a flush is
//   requested, it sweeps every entry to CLR_VALUE. Outside a sweep it shares
//   the single write port between a fill and an update requester. Fill has
//   priority, but update cannot be starved for more than MAX_STREAK grants.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   fill_req_i/addr/data  fill request, held until fill_gnt_o
//   fill_gnt_o            combinational accept for fill
//   upd_req_i/addr/data   update request, held until upd_gnt_o
//   upd_gnt_o             combinational accept for update
//   flush_req_i           one-cycle pulse that restarts a full clear sweep
//   init_done_o           registered; RAM contents are valid
//   busy_o                registered; high while sweeping
//   write_addr_o/data_o   registered RAM write address/data
//   write_wen_o           registered RAM write enable
// ---------------------------------------------------------------------------
`ifndef PDC_WIDTH
`define PDC_WIDTH 32
`endif

module pdc_wr_sched #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = `PDC_WIDTH,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0,
  parameter int unsigned MAX_STREAK = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fill_req_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output logic              fill_gnt_o,
  input  logic              upd_req_i,
  input  logic [ADDR_W-1:0] upd_addr_i,
  input  logic [DATA_W-1:0] upd_data_i,
  output logic              upd_gnt_o,
  input  logic              flush_req_i,
  output logic              init_done_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] write_addr_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic              write_wen_o
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic [2:0]        MaxStreak = 3'(MAX_STREAK);
  localparam logic [ADDR_W-1:0] LastAddr  = '1;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic [ADDR_W-1:0]   clr_ptr_d;
  logic [2:0]          streak_q;
  logic                init_done_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   write_addr_q;
  logic [DATA_W-1:0]   write_data_q;
  logic                write_wen_q;
  logic                grant_ok;
  logic                upd_turn;

  // Sweep pointer advances by one and wraps naturally at the last entry.
  assign clr_ptr_d = clr_ptr_q + 1'b1;

  // Grants only exist in RUN, never during reset or in a flush cycle. When
  // both requesters wait, update wins only once fill has used its streak.
  assign grant_ok   = (state_q == RUN) && !rst_i && !flush_req_i;
  assign upd_turn   = upd_req_i && (!fill_req_i || (streak_q == MaxStreak));
  assign fill_gnt_o = grant_ok && fill_req_i && !upd_turn;
  assign upd_gnt_o  = grant_ok && upd_turn;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= CLEAR;
      clr_ptr_q    <= '0;
      streak_q     <= '0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b1;
      write_addr_q <= '0;
      write_data_q <= '0;
      write_wen_q  <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          streak_q <= '0;
          if (flush_req_i) begin
            // Restart the sweep from entry 0; nothing is written this edge.
            clr_ptr_q   <= '0;
            write_wen_q <= 1'b0;
          end else begin
            write_wen_q  <= 1'b1;
            write_addr_q <= clr_ptr_q;
            write_data_q <= CLR_VALUE;
            clr_ptr_q    <= clr_ptr_d;
            // The last clear write and init_done become visible together.
            if (clr_ptr_q == LastAddr) begin
              state_q     <= RUN;
              init_done_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        RUN: begin
          if (flush_req_i) begin
            state_q     <= CLEAR;
            clr_ptr_q   <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            streak_q    <= '0;
            write_wen_q <= 1'b0;
          end else begin
            if (fill_gnt_o) begin
              write_wen_q  <= 1'b1;
              write_addr_q <= fill_addr_i;
              write_data_q <= fill_data_i;
            end else if (upd_gnt_o) begin
              write_wen_q  <= 1'b1;
              write_addr_q <= upd_addr_i;
              write_data_q <= upd_data_i;
            end else begin
              write_wen_q <= 1'b0;
            end
            // Streak counts fills taken while update is kept waiting.
            if (upd_gnt_o || !upd_req_i) begin
              streak_q <= '0;
            end else if (fill_gnt_o && (streak_q != 3'd7)) begin
              streak_q <= streak_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= CLEAR;
        end
      endcase
    end
  end

  assign init_done_o  = init_done_q;
  assign busy_o       = busy_q;
  assign write_addr_o = write_addr_q;
  assign write_data_o = write_data_q;
  assign write_wen_o  = write_wen_q;

endmodule

// File: doc/pdc_wr_sched.md
Name: pdc_wr_sched

Overview:
- Write-port controller for the 2048-entry pdc RAM; sole driver of its write_addr/write_data/write_wen.
- After reset, and on flush request, sweeps every entry to CLR_VALUE.
- Outside a sweep, arbitrates the single write port between a fill requester and an update requester, with fill priority plus starvation protection for update.
- Exports init_done so read-side logic ignores the RAM until the sweep completes.

Parameters:
- ADDR_W, 11, RAM address width; entries = 2^ADDR_W.
- DATA_W, `pdc_width, RAM data width.
- CLR_VALUE, 0, value written to every entry during a sweep (DATA_W bits).
- MAX_STREAK, 3, consecutive fill grants allowed while update waits; 1..7.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fill_req  in  1  fill write request; held with addr/data until fill_gnt.
- fill_addr  in  ADDR_W  fill address.
- fill_data  in  DATA_W  fill data.
- fill_gnt  out  1  combinational; request accepted this cycle.
- upd_req  in  1  update write request; same hold rule.
- upd_addr  in  ADDR_W  update address.
- upd_data  in  DATA_W  update data.
- upd_gnt  out  1  combinational; request accepted this cycle.
- flush_req  in  1  single-cycle pulse; start a full clear sweep.
- init_done  out  1  registered; RAM contents valid.
- busy  out  1  registered; high while sweeping.
- write_addr  out  ADDR_W  registered; to RAM.
- write_data  out  DATA_W  registered; to RAM.
- write_wen  out  1  registered; to RAM.

Behaviour:
- States: CLEAR, RUN. Registers: state, clr_ptr[ADDR_W], streak[3].
- Reset values while rst=1: state=CLEAR, clr_ptr=0, streak=0, write_wen=0, write_addr=0, write_data=0, init_done=0, busy=1. fill_gnt and upd_gnt are 0 throughout reset.
- CLEAR, each cycle:
  - Register write_wen=1, write_addr=clr_ptr, write_data=CLR_VALUE; clr_ptr++.
  - The first clear write appears on the first edge with rst=0. Exactly 2^ADDR_W writes, addresses ascending 0..2047.
  - When clr_ptr==max: state<=RUN, init_done<=1, busy<=0 on that same edge. The write to addr max and init_done=1 become visible together.
  - No grants in CLEAR.
- RUN grant rule (combinational, no grant when flush_req=1):
  - Only fill_req: fill_gnt.
  - Only upd_req: upd_gnt.
  - Both: upd_gnt if streak==MAX_STREAK, else fill_gnt.
  - Never both grants in one cycle.
- Write latency: the granted request's addr/data appear on write_addr/write_data with write_wen=1 one edge after the grant cycle. When no grant, write_wen<=0; write_addr/write_data hold their last values.
- Streak:
  - Increments (saturating) on a fill grant while upd_req=1.
  - Resets to 0 on an upd grant, or in any cycle upd_req=0.
  - Worst-case update wait: MAX_STREAK+1 cycles.
- Same-address traffic is not merged. RAM order equals grant order.
- flush_req in RUN:
  - No grant that cycle.
  - Next edge: state<=CLEAR, clr_ptr<=0, init_done<=0, busy<=1, streak<=0, write_wen<=0.
  - The sweep starts one edge later.
- flush_req in CLEAR: clr_ptr<=0 (sweep restarts); write_wen<=0 that edge.
- rst mid-sweep or mid-RUN: immediate return to reset values on that edge. A pending request stays pending; the requester keeps holding it until granted.
- fill_req/upd_req asserted during CLEAR: held, served in the first RUN cycle.
- Address arithmetic wraps modulo 2^ADDR_W; clr_ptr wraps to 0 at the sweep end.
- RAM read latency (2 cycles) is outside this block. Readers gate on init_done.

Test Plan:
- Release rst, no requests -> write_wen=1 for 2048 consecutive cycles, addr 0..2047, data 0. init_done=1 in the cycle showing addr 2047; busy falls with it.
- After init, fill_req addr 5 data 0xAA for 1 cycle -> fill_gnt same cycle; next cycle write_addr=5, write_data=0xAA, write_wen=1; the cycle after, write_wen=0.
- fill_req and upd_req both held continuously, MAX_STREAK=3 -> grant sequence F,F,F,U,F,F,F,U. Each write appears one cycle after its grant.
- flush_req pulse while both requests pending -> no grant that cycle. init_done=0 and write_wen=0 next cycle, then a 2048-write sweep. Requests are granted (fill first) in the first cycle after init_done=1.
- flush_req at sweep addr 1000 -> the next write is addr 0, and the sweep completes 2048 writes later.
- rst asserted at sweep addr 500 for 1 cycle, then released -> sweep restarts at addr 0; init_done stays 0 until addr 2047 is written.
